// File: rtl/spi_sync_filter_buffer_pkg.sv
// spi_sync_filter_buffer_pkg: SPI mode encodings, default channel indices, filter helpers.
package spi_sync_filter_buffer_pkg;
  typedef enum logic [1:0] {MODE0 = 2'b00, MODE1 = 2'b01, MODE2 = 2'b10, MODE3 = 2'b11} spi_mode_e;
  localparam int DEF_SCK_IDX  = 0;
  localparam int DEF_CS_IDX   = 1;
  localparam int DEF_MOSI_IDX = 2;
  function automatic int cnt_width(input int filter_len);
    return (filter_len > 1) ? $clog2(filter_len) : 1;
  endfunction
endpackage

// File: rtl/spi_sync_filter_buffer_if.sv
// spi_sync_filter_buffer_if: raw pad inputs, mode controls and conditioned outputs.
interface spi_sync_filter_buffer_if #(parameter int NUM_CH = 3);
  logic              i_EN;
  logic [NUM_CH-1:0] i_D;
  logic              i_CPOL;
  logic              i_CPHA;
  logic [NUM_CH-1:0] o_Q;
  logic [NUM_CH-1:0] o_RISE;
  logic [NUM_CH-1:0] o_FALL;
  logic              o_SAMPLE;
  logic              o_SHIFT;
  logic              o_CS_START;
  logic              o_CS_END;
  modport slave (input i_EN, i_D, i_CPOL, i_CPHA,
                 output o_Q, o_RISE, o_FALL, o_SAMPLE, o_SHIFT, o_CS_START, o_CS_END);
  modport master (output i_EN, i_D, i_CPOL, i_CPHA,
                  input o_Q, o_RISE, o_FALL, o_SAMPLE, o_SHIFT, o_CS_START, o_CS_END);
endinterface

// File: rtl/spi_sync_filter_buffer_deglitch_ch.sv
// spi_deglitch_ch: one channel's synchroniser, stable-sample filter and edge pulses.
module spi_deglitch_ch
  import spi_sync_filter_buffer_pkg::*;
#(
  parameter int   SYNC_DEPTH = 2,
  parameter int   FILTER_LEN = 1,
  parameter logic RESET_BIT  = 1'b0
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_EN,
  input  logic i_D,
  output logic o_Q,
  output logic o_RISE,
  output logic o_FALL
);
  localparam int CW = cnt_width(FILTER_LEN);
  logic [SYNC_DEPTH-1:0] r_sync;
  logic [CW-1:0]         r_cnt;
  logic                  r_q;
  logic                  r_rise;
  logic                  r_fall;
  logic                  w_v;
  logic                  w_upd;
  assign w_v   = r_sync[SYNC_DEPTH-1];
  assign w_upd = (w_v != r_q) && (r_cnt == CW'(FILTER_LEN - 1));
  // Any sample that agrees with the current level restarts the stability count.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_sync <= {SYNC_DEPTH{RESET_BIT}};
      r_cnt  <= '0;
      r_q    <= RESET_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_EN) begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_D};
      r_cnt  <= (w_v == r_q || w_upd) ? '0 : r_cnt + CW'(1);
      r_q    <= w_upd ? w_v : r_q;
      r_rise <= w_upd & w_v;
      r_fall <= w_upd & ~w_v;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end
  assign o_Q    = r_q;
  assign o_RISE = r_rise;
  assign o_FALL = r_fall;
endmodule

// File: rtl/spi_sync_filter_buffer.sv
// spi_sync_filter_buffer: per-channel pad conditioning plus SPI mode strobe decode.
module spi_sync_filter_buffer
  import spi_sync_filter_buffer_pkg::*;
#(
  parameter int                NUM_CH     = 3,
  parameter int                SYNC_DEPTH = 2,
  parameter int                FILTER_LEN = 1,
  parameter logic [NUM_CH-1:0] RESET_VAL  = 3'b010,
  parameter int                SCK_IDX    = DEF_SCK_IDX,
  parameter int                CS_IDX     = DEF_CS_IDX
) (
  input logic                     i_CLK,
  input logic                     i_RST_N,
  spi_sync_filter_buffer_if.slave bus
);
  localparam bit LEGAL = (NUM_CH >= 2) && (SYNC_DEPTH >= 2) && (FILTER_LEN >= 1) &&
                         (SCK_IDX >= 0) && (SCK_IDX < NUM_CH) &&
                         (CS_IDX >= 0) && (CS_IDX < NUM_CH) && (SCK_IDX != CS_IDX);
  if (!LEGAL) begin : g_bad_params
    $error("spi_sync_filter_buffer: illegal parameter combination");
  end
  logic [NUM_CH-1:0] w_q;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spi_deglitch_ch #(
      .SYNC_DEPTH(SYNC_DEPTH),
      .FILTER_LEN(FILTER_LEN),
      .RESET_BIT (RESET_VAL[g])
    ) u_ch (
      .i_CLK  (i_CLK),
      .i_RST_N(i_RST_N),
      .i_EN   (bus.i_EN),
      .i_D    (bus.i_D[g]),
      .o_Q    (w_q[g]),
      .o_RISE (w_rise[g]),
      .o_FALL (w_fall[g])
    );
  end
  spi_mode_e w_mode;
  logic      w_lead;
  logic      w_trail;
  logic      w_act;
  logic      w_cpha;
  // Strobes use the already-updated CS level, so a CS fall in the same cycle still qualifies.
  always_comb begin
    w_mode  = spi_mode_e'({bus.i_CPOL, bus.i_CPHA});
    w_cpha  = (w_mode == MODE1) || (w_mode == MODE3);
    w_lead  = (w_mode == MODE2 || w_mode == MODE3) ? w_fall[SCK_IDX] : w_rise[SCK_IDX];
    w_trail = (w_mode == MODE2 || w_mode == MODE3) ? w_rise[SCK_IDX] : w_fall[SCK_IDX];
    w_act   = ~w_q[CS_IDX];
  end
  assign bus.o_Q        = w_q;
  assign bus.o_RISE     = w_rise;
  assign bus.o_FALL     = w_fall;
  assign bus.o_SAMPLE   = w_act & (w_cpha ? w_trail : w_lead);
  assign bus.o_SHIFT    = w_act & (w_cpha ? w_lead : w_trail);
  assign bus.o_CS_START = w_fall[CS_IDX];
  assign bus.o_CS_END   = w_rise[CS_IDX];
endmodule
